rr_mux_arb: RTL and testbench

- Parametrised successor to the combinational 2:1 mux: an N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Channel selection is not driven by an external select line. An internal arbiter chooses the channel, using either fixed priority or round-robin.
- Sits between multiple word producers (for example ALU result, memory read, I/O) and a single consumer bus in the CPU datapath.

---
 rtl/rr_mux_arb.sv | 91 +++++++++
 tb/tb_rr_mux_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with valid/ready on every port.
// An internal arbiter (fixed priority or round-robin) picks the source channel.
module rr_mux_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N-1:0]                   in_valid,
    output logic [N-1:0]                   in_ready,
    input  logic [N*WIDTH-1:0]             in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_chan
);

    localparam int unsigned CHAN_W = (N > 1) ? $clog2(N) : 1;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [CHAN_W-1:0] r_out_chan;
    logic [CHAN_W-1:0] r_ptr;

    logic              w_load;
    logic              w_found;
    logic              w_xfer;
    logic [CHAN_W-1:0] w_base;
    logic [CHAN_W-1:0] w_idx;
    logic [CHAN_W-1:0] w_winner;
    logic [CHAN_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0]  w_words [N];

    assign w_load = !r_out_valid || out_ready;
    assign w_base = (MODE == 1) ? r_ptr : '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_words[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan channels starting at w_base, wrapping modulo N; first valid one wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = CHAN_W'((int'(w_base) + k) % N);
            if (!w_found && in_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_load && w_found && !reset) begin
            in_ready[w_winner] = 1'b1;
        end
    end

    assign w_xfer    = |in_ready;
    assign w_ptr_nxt = (w_winner == CHAN_W'(N - 1)) ? '0 : w_winner + CHAN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_words[w_winner];
            r_out_chan  <= w_winner;
            if (MODE == 1) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (r_out_valid && out_ready) begin
            // Drain: data/chan keep their last value.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: a round-robin and a fixed-priority instance share inputs and are
// compared against a per-cycle behavioural model plus constant vector tables.
module tb_rr_mux_arb;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic        ordy;
    logic [63:0] vdata;

    logic [3:0]  rdy_o  [2];
    logic        ov_o   [2];
    logic [15:0] od_o   [2];
    logic [1:0]  oc_o   [2];

    always #5 clk = ~clk;

    rr_mux_arb #(.WIDTH(16), .N(4), .MODE(0)) dut_fp (
        .clk(clk), .reset(rst), .in_valid(vld), .in_ready(rdy_o[0]), .in_data(vdata),
        .out_valid(ov_o[0]), .out_ready(ordy), .out_data(od_o[0]), .out_chan(oc_o[0])
    );

    rr_mux_arb #(.WIDTH(16), .N(4), .MODE(1)) dut_rr (
        .clk(clk), .reset(rst), .in_valid(vld), .in_ready(rdy_o[1]), .in_data(vdata),
        .out_valid(ov_o[1]), .out_ready(ordy), .out_data(od_o[1]), .out_chan(oc_o[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference state per mode (index 0 = fixed priority, 1 = round-robin).
    int          m_ptr [2];
    bit          m_ov  [2];
    logic [15:0] m_od  [2];
    int          m_oc  [2];
    logic [3:0]  s_rdy_pre [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input int mode, input logic [3:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mode == 1) ? (ptr + k) % N : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] word_of(input logic [63:0] d, input int i);
        return 16'(d >> (16 * i));
    endfunction

    // One clock: check handshake before the edge, advance model, check outputs after it.
    task automatic step();
        #3;
        for (int m = 0; m < 2; m++) begin
            int w;
            logic [3:0] er;
            w  = winner(m, vld, m_ptr[m]);
            er = (!rst && (!m_ov[m] || ordy) && w >= 0) ? 4'(1 << w) : 4'h0;
            s_rdy_pre[m] = rdy_o[m];
            chk(m == 1 ? "model_rr_in_ready" : "model_fp_in_ready", 64'(rdy_o[m]), 64'(er));
            if (rst) begin
                m_ov[m] = 1'b0; m_od[m] = '0; m_oc[m] = 0; m_ptr[m] = 0;
            end else if (er != 4'h0) begin
                m_ov[m] = 1'b1; m_od[m] = word_of(vdata, w); m_oc[m] = w;
                if (m == 1) m_ptr[m] = (w + 1) % N;
            end else if (m_ov[m] && ordy) begin
                m_ov[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk(m == 1 ? "model_rr_out_valid" : "model_fp_out_valid", 64'(ov_o[m]), 64'(m_ov[m]));
            chk(m == 1 ? "model_rr_out_data" : "model_fp_out_data", 64'(od_o[m]), 64'(m_od[m]));
            chk(m == 1 ? "model_rr_out_chan" : "model_fp_out_chan", 64'(oc_o[m]), 64'(m_oc[m]));
        end
    endtask

    task automatic chk_rr(input string name, input logic [3:0] er, input logic eov,
                          input logic [1:0] ech, input logic [15:0] ed);
        chk({name, "_in_ready"}, 64'(s_rdy_pre[1]), 64'(er));
        chk({name, "_out_valid"}, 64'(ov_o[1]), 64'(eov));
        chk({name, "_out_chan"}, 64'(oc_o[1]), 64'(ech));
        chk({name, "_out_data"}, 64'(od_o[1]), 64'(ed));
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        ordy;
        logic [63:0] data;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_chan;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        localparam logic [63:0] D = 64'h00A3_00A2_00A1_00A0;
        tbl[0] = '{1'b1, 4'hF, 1'b1, D, 4'h0, 1'b0, 2'd0, 16'h0000};
        tbl[1] = '{1'b1, 4'hF, 1'b1, D, 4'h0, 1'b0, 2'd0, 16'h0000};
        tbl[2] = '{1'b0, 4'h1, 1'b1, 64'h00A3_00A2_00A1_1234, 4'h1, 1'b1, 2'd0, 16'h1234};
        tbl[3] = '{1'b1, 4'hF, 1'b1, D, 4'h0, 1'b0, 2'd0, 16'h0000};
        tbl[4] = '{1'b0, 4'hF, 1'b1, D, 4'h1, 1'b1, 2'd0, 16'h00A0};
        tbl[5] = '{1'b0, 4'hF, 1'b1, D, 4'h2, 1'b1, 2'd1, 16'h00A1};
        tbl[6] = '{1'b0, 4'hF, 1'b1, D, 4'h4, 1'b1, 2'd2, 16'h00A2};
        tbl[7] = '{1'b0, 4'hF, 1'b1, D, 4'h8, 1'b1, 2'd3, 16'h00A3};
        tbl[8] = '{1'b0, 4'hF, 1'b1, D, 4'h1, 1'b1, 2'd0, 16'h00A0};
        tbl[9] = '{1'b0, 4'hF, 1'b1, D, 4'h2, 1'b1, 2'd1, 16'h00A1};

        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_ov[m] = 1'b0; m_od[m] = '0; m_oc[m] = 0;
        end
        rst = 1'b1; vld = 4'h0; ordy = 1'b0; vdata = '0;
        @(posedge clk);
        #1;

        // Reset, first transfer, round-robin fairness.
        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].rst; vld = tbl[r].vld; ordy = tbl[r].ordy; vdata = tbl[r].data;
            step();
            chk_rr($sformatf("tbl%0d", r), tbl[r].e_rdy, tbl[r].e_ov, tbl[r].e_chan,
                   tbl[r].e_data);
        end

        // Backpressure: BEEF from channel 2 held for 3 stalled cycles.
        vdata = 64'h3333_BEEF_1111_0000;
        vld = 4'h4; ordy = 1'b1;
        step();
        chk_rr("bp_load", 4'h4, 1'b1, 2'd2, 16'hBEEF);
        vld = 4'hF; ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_rr($sformatf("bp_stall%0d", c), 4'h0, 1'b1, 2'd2, 16'hBEEF);
        end
        ordy = 1'b1;
        step();
        chk_rr("bp_release", 4'h8, 1'b1, 2'd3, 16'h3333);

        // Pointer wrap with sparse requests.
        vld = 4'h4;
        step();
        chk_rr("wrap_sparse2", 4'h4, 1'b1, 2'd2, 16'hBEEF);
        vld = 4'h9;
        step();
        chk_rr("wrap_ptr3", 4'h8, 1'b1, 2'd3, 16'h3333);

        // Reset while a word is stalled at the output.
        vdata = 64'h3333_BEEF_1111_5555;
        vld = 4'h1; ordy = 1'b1;
        step();
        chk_rr("mr_load", 4'h1, 1'b1, 2'd0, 16'h5555);
        vld = 4'h0; ordy = 1'b0;
        step();
        chk_rr("mr_hold", 4'h0, 1'b1, 2'd0, 16'h5555);
        rst = 1'b1; vld = 4'hF;
        step();
        chk_rr("mr_reset", 4'h0, 1'b0, 2'd0, 16'h0000);
        rst = 1'b0; ordy = 1'b1;
        step();
        chk_rr("mr_first", 4'h1, 1'b1, 2'd0, 16'h5555);

        // Fixed priority on the MODE 0 instance.
        vld = 4'hE;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("fp_e_rdy%0d", c), 64'(s_rdy_pre[0]), 64'h2);
            chk($sformatf("fp_e_chan%0d", c), 64'(oc_o[0]), 64'd1);
        end
        vld = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("fp_f_rdy%0d", c), 64'(s_rdy_pre[0]), 64'h1);
            chk($sformatf("fp_f_chan%0d", c), 64'(oc_o[0]), 64'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            vld   = 4'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            vdata = {$urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
